// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, constants.
// No logic of its own; latency n/a.
// No flow control; pure type/constant container.
package mdu_pkg;

    // Op encodings driven by the control unit
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DZ   = 2'b11
    } state_t;

    // LO value written by a divide-by-zero; sliced down to the operand width by users
    localparam int                     MAX_BITWIDTH = 64;
    localparam logic [MAX_BITWIDTH-1:0] DZ_LO       = '1;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational, zero latency.
// No handshake; the caller registers the result every cycle.
module mdu_div_step #(
    parameter int bitwidth = 32
) (
    input  logic [bitwidth-1:0] i_rem,
    input  logic                i_dvd_bit,
    input  logic [bitwidth-1:0] i_divisor,
    output logic [bitwidth-1:0] o_rem,
    output logic                o_q_bit
);

    logic [bitwidth:0] w_shift;
    logic [bitwidth:0] w_diff;

    // The incoming remainder is always below the divisor, so the shifted value
    // minus the divisor fits in bitwidth bits whenever it does not borrow.
    always_comb begin
        w_shift = {i_rem, i_dvd_bit};
        w_diff  = w_shift - {1'b0, i_divisor};
        o_q_bit = ~w_diff[bitwidth];
        o_rem   = o_q_bit ? w_diff[bitwidth-1:0] : w_shift[bitwidth-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative unsigned MULTU/DIVU with HI/LO registers; MTHI/MTLO write directly.
// Latency: bitwidth cycles for MULTU/DIVU, 1 cycle for DIVU by zero, MTHI/MTLO at the issue edge.
// Backpressure: busy is high while iterating and start is ignored (not sampled) until it drops.
module mult_div_unit #(
    parameter int bitwidth = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [bitwidth-1:0] a,
    input  logic [bitwidth-1:0] b,
    output logic                busy,
    output logic                done,
    output logic                div_by_zero,
    output logic [bitwidth-1:0] hi,
    output logic [bitwidth-1:0] lo
);

    import mdu_pkg::*;

    localparam int                CNT_W    = $clog2(bitwidth) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(bitwidth - 1);
    localparam logic [bitwidth-1:0] LO_SAT = DZ_LO[bitwidth-1:0];

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_dbz;
    logic [bitwidth-1:0]     r_hi;
    logic [bitwidth-1:0]     r_lo;
    // Multiplicand (MUL), divisor (DIV) or saved dividend (DZ)
    logic [bitwidth-1:0]     r_opnd;
    // Working register: {partial product, remaining multiplier} or {remainder, dividend/quotient}
    logic [2*bitwidth-1:0]   r_acc;
    logic [CNT_W-1:0]        r_cnt;

    logic [bitwidth:0]       w_add;
    logic [2*bitwidth-1:0]   w_mul_next;
    logic [bitwidth-1:0]     w_rem;
    logic                    w_q_bit;
    logic [2*bitwidth-1:0]   w_div_next;

    // Shift-add multiply step: add the multiplicand if the current multiplier bit is set, then shift right
    always_comb begin
        w_add = {1'b0, r_acc[2*bitwidth-1:bitwidth]};
        if (r_acc[0]) begin
            w_add = {1'b0, r_acc[2*bitwidth-1:bitwidth]} + {1'b0, r_opnd};
        end
        w_mul_next = {w_add, r_acc[bitwidth-1:1]};
    end

    mdu_div_step #(
        .bitwidth (bitwidth)
    ) u_div_step (
        .i_rem     (r_acc[2*bitwidth-1:bitwidth]),
        .i_dvd_bit (r_acc[bitwidth-1]),
        .i_divisor (r_opnd),
        .o_rem     (w_rem),
        .o_q_bit   (w_q_bit)
    );

    // Quotient bits enter at the bottom as dividend bits leave the top
    always_comb begin
        w_div_next = {w_rem, r_acc[bitwidth-2:0], w_q_bit};
    end

    // Sequencer: accepts ops in IDLE, iterates, and commits HI/LO only on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULTU: begin
                                r_opnd  <= a;
                                r_acc   <= {{bitwidth{1'b0}}, b};
                                r_cnt   <= '0;
                                r_dbz   <= 1'b0;
                                r_busy  <= 1'b1;
                                r_state <= MUL;
                            end
                            OP_DIVU: begin
                                r_cnt  <= '0;
                                r_dbz  <= 1'b0;
                                r_busy <= 1'b1;
                                if (b == '0) begin
                                    r_opnd  <= a;
                                    r_state <= DZ;
                                end else begin
                                    r_opnd  <= b;
                                    r_acc   <= {{bitwidth{1'b0}}, a};
                                    r_state <= DIV;
                                end
                            end
                            OP_MTHI: r_hi <= a;
                            default: r_lo <= a;
                        endcase
                    end
                end
                MUL: begin
                    r_acc <= w_mul_next;
                    if (r_cnt == CNT_LAST) begin
                        r_hi    <= w_mul_next[2*bitwidth-1:bitwidth];
                        r_lo    <= w_mul_next[bitwidth-1:0];
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DIV: begin
                    r_acc <= w_div_next;
                    if (r_cnt == CNT_LAST) begin
                        r_hi    <= w_div_next[2*bitwidth-1:bitwidth];
                        r_lo    <= w_div_next[bitwidth-1:0];
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_hi    <= r_opnd;
                    r_lo    <= LO_SAT;
                    r_dbz   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO/flag,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;

    mult_div_unit #(.bitwidth(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l, input logic z);
        exp_t e;
        e.hi  = h;
        e.lo  = l;
        e.dbz = z;
        sb.push_back(e);
    endtask

    // Drives start for exactly one edge; returns at the negedge after the accepting edge.
    // Operands are scrambled afterwards so only latched values can produce the result.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0;
    endtask

    // Counts negedges with busy high, bounded
    task automatic measure_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            n_done++;
            check("busy_with_done", {63'd0, busy}, 64'd0);
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                e = sb.pop_front();
                check("hi", {32'd0, hi}, {32'd0, e.hi});
                check("lo", {32'd0, lo}, {32'd0, e.lo});
                check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int snap;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;

        // MULTU max*max
        push(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        measure_busy(n);
        check("mul_busy_cycles", 64'(n), 64'd32);

        // DIVU 100/7
        push(32'd2, 32'd14, 1'b0);
        issue(2'b01, 32'd100, 32'd7);
        measure_busy(n);
        check("div_busy_cycles", 64'(n), 64'd32);

        // DIVU by zero, then MULTU clears the flag
        push(32'd5, 32'hFFFF_FFFF, 1'b1);
        issue(2'b01, 32'd5, 32'd0);
        measure_busy(n);
        check("dz_busy_cycles", 64'(n), 64'd1);
        push(32'd0, 32'd12, 1'b0);
        issue(2'b00, 32'd3, 32'd4);
        check("dbz_cleared_on_accept", {63'd0, div_by_zero}, 64'd0);
        measure_busy(n);
        check("mul2_busy_cycles", 64'(n), 64'd32);

        // MULTU 6*7 with an ignored DIVU start mid-operation
        push(32'd0, 32'd42, 1'b0);
        issue(2'b00, 32'd6, 32'd7);
        repeat (3) @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd9;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        measure_busy(n);
        check("ignored_start_busy_cycles", 64'(4 + n), 64'd32);
        repeat (40) @(negedge clk);
        check("ignored_start_idle", {63'd0, busy}, 64'd0);

        // MTHI / MTLO
        issue(2'b10, 32'h1234, 32'h0);
        check("mthi_hi", {32'd0, hi}, 64'h1234);
        check("mthi_lo_kept", {32'd0, lo}, 64'd42);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        issue(2'b11, 32'h5678, 32'h0);
        check("mtlo_lo", {32'd0, lo}, 64'h5678);
        check("mtlo_hi_kept", {32'd0, hi}, 64'h1234);
        check("mtlo_busy_done", {62'd0, busy, done}, 64'd0);

        // Reset mid-MULTU aborts without a result
        snap = n_done;
        issue(2'b00, 32'h0001_0000, 32'h0001_0000);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(n_done), 64'(snap));

        push(32'd0, 32'd6, 1'b0);
        issue(2'b00, 32'd2, 32'd3);
        measure_busy(n);
        check("post_abort_busy_cycles", 64'(n), 64'd32);
        repeat (3) @(negedge clk);

        check("done_count", 64'(n_done), 64'd6);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
